// File: rtl/prio_encoder_rr_if.sv
// Request/result handshake bundle for prio_encoder_rr.
// master drives requests and consumes results; slave is the encoder.
interface prio_encoder_rr_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
);
  logic         req_valid;
  logic [N-1:0] req;
  logic         rr_en;
  logic         req_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic         out_none;
  logic         out_multi;
  logic         out_ready;

  modport master (
    output req_valid, req, rr_en, out_ready,
    input  req_ready, out_valid, out_idx, out_none, out_multi
  );

  modport slave (
    input  req_valid, req, rr_en, out_ready,
    output req_ready, out_valid, out_idx, out_none, out_multi
  );
endinterface

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) encoder with fixed-priority or round-robin selection,
// valid/ready on both sides, and flags for empty and multi-hot requests.
module prio_encoder_rr #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  prio_encoder_rr_if.slave bus
);
  localparam int W = $clog2(N);

  logic [W-1:0] ptr_reg;
  logic [W-1:0] ptr_next;
  logic [W-1:0] fixed_idx;
  logic [W-1:0] rr_idx;
  logic [W-1:0] win_idx;
  logic [W:0]   probe;
  logic         rr_found;
  logic         req_none;
  logic         req_multi;
  logic         req_ready;
  logic         accept;
  logic         pop;

  logic         out_valid_reg;
  logic [W-1:0] out_idx_reg;
  logic         out_none_reg;
  logic         out_multi_reg;

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    fixed_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i]) fixed_idx = W'(i);
    end
  end

  // Ascending search from ptr; the explicit wrap keeps the probe inside 0..N-1
  // even when N is not a power of two.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    probe    = '0;
    for (int k = 0; k < N; k++) begin
      probe = {1'b0, ptr_reg} + (W+1)'(k);
      if (probe >= (W+1)'(N)) probe = probe - (W+1)'(N);
      if (!rr_found && bus.req[probe[W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = probe[W-1:0];
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign req_multi = |(bus.req & (bus.req - N'(1)));
  assign req_none  = ~|bus.req;
  assign win_idx   = bus.rr_en ? rr_idx : fixed_idx;
  assign ptr_next  = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);

  assign req_ready = !out_valid_reg | bus.out_ready;
  assign accept    = bus.req_valid & req_ready;
  assign pop       = out_valid_reg & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
      out_none_reg  <= 1'b0;
      out_multi_reg <= 1'b0;
      ptr_reg       <= '0;
    end else begin
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_idx_reg   <= req_none ? '0 : win_idx;
        out_none_reg  <= req_none;
        out_multi_reg <= req_multi;
        if (bus.rr_en && !req_none) ptr_reg <= ptr_next;
      end else if (pop) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_idx   = out_idx_reg;
  assign bus.out_none  = out_none_reg;
  assign bus.out_multi = out_multi_reg;
endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr: an N=8 and an N=5 instance share clock and reset.
module tb_prio_encoder_rr;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  prio_encoder_rr_if #(.N(8)) b8 ();
  prio_encoder_rr_if #(.N(5)) b5 ();

  prio_encoder_rr #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  prio_encoder_rr #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    b8.req_valid = 1'b1; b8.req = 8'hFF; b8.rr_en = 1'b1; b8.out_ready = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (b8.out_valid !== 1'b0 || b8.out_idx !== 3'd0 || b8.out_none !== 1'b0 || b8.out_multi !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b idx=%0d none=%b multi=%b want 0 0 0 0",
               b8.out_valid, b8.out_idx, b8.out_none, b8.out_multi);
    end
    rst_n = 1'b1;
    tick();
    $display("txn reset_release req=%h idx=%0d valid=%b", b8.req, b8.out_idx, b8.out_valid);
    checks++;
    if (b8.out_valid !== 1'b1 || b8.out_idx !== 3'd0 || b8.out_multi !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_rr got v=%b idx=%0d multi=%b want 1 0 1",
               b8.out_valid, b8.out_idx, b8.out_multi);
    end
  endtask

  task automatic test_fixed_sweep();
    logic [7:0] r;
    b8.rr_en = 1'b0; b8.out_ready = 1'b1; b8.req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r = 8'h01 << i;
      b8.req = r;
      tick();
      $display("txn fixed_sweep req=%h idx=%0d", r, b8.out_idx);
      checks++;
      if (b8.out_valid !== 1'b1 || b8.out_idx !== 3'(i) || b8.out_none !== 1'b0 || b8.out_multi !== 1'b0) begin
        errors++;
        $display("FAIL fixed_sweep[%0d] got v=%b idx=%0d none=%b multi=%b want 1 %0d 0 0",
                 i, b8.out_valid, b8.out_idx, b8.out_none, b8.out_multi, i);
      end
    end
  endtask

  task automatic test_fixed_multi_empty();
    b8.rr_en = 1'b0; b8.req_valid = 1'b1; b8.out_ready = 1'b1;
    b8.req = 8'b0010_0100;
    tick();
    $display("txn fixed_multi req=%h idx=%0d", b8.req, b8.out_idx);
    checks++;
    if (b8.out_idx !== 3'd2 || b8.out_multi !== 1'b1 || b8.out_none !== 1'b0) begin
      errors++;
      $display("FAIL fixed_multi got idx=%0d multi=%b none=%b want 2 1 0", b8.out_idx, b8.out_multi, b8.out_none);
    end
    b8.req = 8'h00;
    tick();
    $display("txn fixed_empty req=%h idx=%0d", b8.req, b8.out_idx);
    checks++;
    if (b8.out_idx !== 3'd0 || b8.out_none !== 1'b1 || b8.out_multi !== 1'b0 || b8.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL fixed_empty got idx=%0d none=%b multi=%b v=%b want 0 1 0 1",
               b8.out_idx, b8.out_none, b8.out_multi, b8.out_valid);
    end
  endtask

  task automatic test_pop_idle();
    b8.req_valid = 1'b0; b8.out_ready = 1'b1;
    tick();
    $display("txn pop_idle valid=%b", b8.out_valid);
    checks++;
    if (b8.out_valid !== 1'b0 || b8.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL pop_idle got v=%b ready=%b want 0 1", b8.out_valid, b8.req_ready);
    end
  endtask

  task automatic test_round_robin();
    int exp_idx[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    b8.req_valid = 1'b0;
    pulse_reset(1);
    b8.rr_en = 1'b1; b8.out_ready = 1'b1; b8.req_valid = 1'b1; b8.req = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      $display("txn rr_ff[%0d] idx=%0d", i, b8.out_idx);
      checks++;
      if (b8.out_valid !== 1'b1 || b8.out_idx !== 3'(exp_idx[i]) || b8.out_multi !== 1'b1) begin
        errors++;
        $display("FAIL rr_ff[%0d] got v=%b idx=%0d multi=%b want 1 %0d 1",
                 i, b8.out_valid, b8.out_idx, b8.out_multi, exp_idx[i]);
      end
    end
    b8.req = 8'b0000_0011;
    tick();
    $display("txn rr_wrap idx=%0d", b8.out_idx);
    checks++;
    if (b8.out_idx !== 3'd0) begin
      errors++;
      $display("FAIL rr_wrap got idx=%0d want 0", b8.out_idx);
    end
    b8.req = 8'h00;
    tick();
    $display("txn rr_empty none=%b", b8.out_none);
    checks++;
    if (b8.out_none !== 1'b1 || b8.out_idx !== 3'd0 || b8.out_multi !== 1'b0) begin
      errors++;
      $display("FAIL rr_empty got none=%b idx=%0d multi=%b want 1 0 0", b8.out_none, b8.out_idx, b8.out_multi);
    end
    // Pointer should still be 1 after the empty request.
    b8.req = 8'hFF;
    tick();
    $display("txn rr_ptr_kept idx=%0d", b8.out_idx);
    checks++;
    if (b8.out_idx !== 3'd1 || b8.out_none !== 1'b0) begin
      errors++;
      $display("FAIL rr_ptr_kept got idx=%0d none=%b want 1 0", b8.out_idx, b8.out_none);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] bp_req[3] = '{8'h01, 8'h02, 8'h04};
    // Pointer is 2 here; 0x80 wins with 7 and wraps the pointer to 0.
    b8.rr_en = 1'b1; b8.out_ready = 1'b1; b8.req_valid = 1'b1; b8.req = 8'h80;
    tick();
    checks++;
    if (b8.out_idx !== 3'd7 || b8.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_load got idx=%0d v=%b want 7 1", b8.out_idx, b8.out_valid);
    end
    b8.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b8.req = bp_req[i];
      #1;
      checks++;
      if (b8.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready[%0d] got %b want 0", i, b8.req_ready);
      end
      tick();
      $display("txn bp_hold[%0d] req=%h idx=%0d valid=%b", i, bp_req[i], b8.out_idx, b8.out_valid);
      checks++;
      if (b8.out_valid !== 1'b1 || b8.out_idx !== 3'd7 || b8.out_none !== 1'b0 || b8.out_multi !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b idx=%0d none=%b multi=%b want 1 7 0 0",
                 i, b8.out_valid, b8.out_idx, b8.out_none, b8.out_multi);
      end
    end
    b8.out_ready = 1'b1; b8.req = 8'h10;
    tick();
    $display("txn bp_release idx=%0d valid=%b", b8.out_idx, b8.out_valid);
    checks++;
    if (b8.out_valid !== 1'b1 || b8.out_idx !== 3'd4) begin
      errors++;
      $display("FAIL bp_release got v=%b idx=%0d want 1 4", b8.out_valid, b8.out_idx);
    end
    b8.req = 8'hFF;
    tick();
    checks++;
    if (b8.out_idx !== 3'd5) begin
      errors++;
      $display("FAIL bp_ptr got idx=%0d want 5", b8.out_idx);
    end
  endtask

  task automatic test_reset_mid();
    b8.req_valid = 1'b0;
    pulse_reset(1);
    b8.rr_en = 1'b1; b8.out_ready = 1'b1; b8.req_valid = 1'b1; b8.req = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (b8.out_idx !== 3'(i)) begin
        errors++;
        $display("FAIL mid_advance[%0d] got idx=%0d want %0d", i, b8.out_idx, i);
      end
    end
    rst_n = 1'b0;
    tick();
    $display("txn mid_reset valid=%b idx=%0d", b8.out_valid, b8.out_idx);
    checks++;
    if (b8.out_valid !== 1'b0 || b8.out_idx !== 3'd0 || b8.out_multi !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got v=%b idx=%0d multi=%b want 0 0 0", b8.out_valid, b8.out_idx, b8.out_multi);
    end
    rst_n = 1'b1;
    tick();
    $display("txn mid_after idx=%0d", b8.out_idx);
    checks++;
    if (b8.out_valid !== 1'b1 || b8.out_idx !== 3'd0) begin
      errors++;
      $display("FAIL mid_after got v=%b idx=%0d want 1 0", b8.out_valid, b8.out_idx);
    end
    b8.req_valid = 1'b0;
  endtask

  task automatic test_n5();
    int exp_idx[6] = '{0, 1, 2, 3, 4, 0};
    b5.rr_en = 1'b1; b5.out_ready = 1'b1; b5.req_valid = 1'b0; b5.req = 5'h1F;
    pulse_reset(1);
    b5.req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      $display("txn n5_rr[%0d] idx=%0d", i, b5.out_idx);
      checks++;
      if (b5.out_valid !== 1'b1 || b5.out_idx !== 3'(exp_idx[i]) || b5.out_multi !== 1'b1) begin
        errors++;
        $display("FAIL n5_rr[%0d] got v=%b idx=%0d multi=%b want 1 %0d 1",
                 i, b5.out_valid, b5.out_idx, b5.out_multi, exp_idx[i]);
      end
    end
    b5.req = 5'h00;
    tick();
    $display("txn n5_empty none=%b", b5.out_none);
    checks++;
    if (b5.out_none !== 1'b1 || b5.out_idx !== 3'd0 || b5.out_multi !== 1'b0) begin
      errors++;
      $display("FAIL n5_empty got none=%b idx=%0d multi=%b want 1 0 0", b5.out_none, b5.out_idx, b5.out_multi);
    end
    b5.req = 5'h1F;
    tick();
    checks++;
    if (b5.out_idx !== 3'd1) begin
      errors++;
      $display("FAIL n5_ptr_kept got idx=%0d want 1", b5.out_idx);
    end
    // Pointer 2: bit 4 wins, pointer wraps to 0, then 0b00011 picks 0.
    b5.req = 5'b10000;
    tick();
    checks++;
    if (b5.out_idx !== 3'd4 || b5.out_multi !== 1'b0) begin
      errors++;
      $display("FAIL n5_top got idx=%0d multi=%b want 4 0", b5.out_idx, b5.out_multi);
    end
    b5.req = 5'b00011;
    tick();
    $display("txn n5_wrap idx=%0d", b5.out_idx);
    checks++;
    if (b5.out_idx !== 3'd0) begin
      errors++;
      $display("FAIL n5_wrap got idx=%0d want 0", b5.out_idx);
    end
    b5.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    b5.req_valid = 1'b0; b5.req = '0; b5.rr_en = 1'b0; b5.out_ready = 1'b1;
    test_reset();
    test_fixed_sweep();
    test_fixed_multi_empty();
    test_pop_idle();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_n5();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
